tc_ps_acp_rx: RTL
=================

Name: tc_ps_acp_rx

Overview:
AXI3 read master on the Zynq PS ACP slave port (S_AXI_ACP_0). It is the read-direction counterpart of the ACP write engine. A single user request (address + ID) becomes one INCR burst of BURST_LEN 64-bit beats. Returned beats stream to the user with zero added latency, under user backpressure. Response errors are reported per transaction.

Parameters:
BURST_LEN, 16, beats per burst (1..16); drives arlen = BURST_LEN-1.
AR_CACHE, 4'b0011, constant driven on arcache.
AR_USER, 5'b00001, constant driven on aruser (ACP coherent-read sideband).

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
rx_en  in  1  read request; accepted only while rx_rdy=1
rx_rdy  out  1  engine idle, ready for a request
rx_araddr  in  32  burst start byte address; bits[2:0] ignored (forced 0)
rx_arid  in  3  transaction ID
rx_rdata  out  64  beat data (= S_AXI_ACP_0_rdata)
rx_rvalid  out  1  beat transferred this cycle
rx_rlast  out  1  final beat of the burst, qualified by rx_rvalid
rx_rready  in  1  user can take a beat this cycle
rx_err  out  1  error status of the last completed burst
S_AXI_ACP_0_araddr out 32; arburst out 2; arcache out 4; arid out 3; arlen out 4; arlock out 2; arprot out 3; arqos out 4; arready in 1; arsize out 3; aruser out 5; arvalid out 1
S_AXI_ACP_0_rdata in 64; rid in 3; rlast in 1; rready out 1; rresp in 2; rvalid in 1

Behaviour:
- Reset (rst=0, async): state=S_CMPT; rx_rdy=0, arvalid=0, araddr=0, arid=0, beat count=0, rx_err=0. rready is low whenever state≠S_DATA.
- Constant outputs: arburst=2'b01 (INCR); arsize=3'b011; arlen=BURST_LEN-1; arlock=0; arprot=0; arqos=0; arcache=AR_CACHE; aruser=AR_USER.
- FSM:
  - S_CMPT: next cycle go to S_IDLE with rx_rdy=1. rx_rdy therefore rises 1 cycle after reset release and 1 cycle after burst end.
  - S_IDLE: on rx_en=1, register araddr={rx_araddr[31:3],3'b0} and arid=rx_arid; set arvalid=1, rx_rdy=0, rx_err=0; go to S_ADDR. If rx_en=0, stay in S_IDLE.
  - S_ADDR: arvalid is held with address/ID stable until arready=1. On that edge arvalid=0 and the FSM goes to S_DATA. arready high before arvalid has no effect.
  - S_DATA: combinational outputs rready=rx_rready and rx_rvalid=rvalid&rready. A beat is counted on rvalid&rready. The counter (5 bits) clears on entry to S_DATA.
    - rx_rlast=rx_rvalid&(rlast | count==BURST_LEN-1).
    - When the beat with count==BURST_LEN-1 or rlast=1 transfers, go to S_CMPT.
- Error rules: on any transferred beat, set rx_err if any of the following holds:
  - rresp≠0
  - rid≠arid
  - rlast=1 with count≠BURST_LEN-1 (early last)
  - rlast=0 with count==BURST_LEN-1 (missing last)
  rx_err is sticky until the next accepted request. It is valid from the cycle rx_rdy rises.
- Early rlast terminates the burst at that beat. For a missing rlast, the burst terminates on the counted final beat.
- rx_en while rx_rdy=0 is ignored; there is no queuing.
- rvalid outside S_DATA is not acknowledged (rready=0).
- 4 KB boundary: the caller guarantees that araddr plus BURST_LEN*8 does not cross 4 KB. No checking is done.
- Latency: rx_en to arvalid is 1 cycle. From the accepted last beat to rx_rdy is 2 cycles (S_CMPT, then S_IDLE).

Decomposition:
- Shared package tc_ps_acp_pkg holds:
  - state encodings S_IDLE=0, S_ADDR=1, S_DATA=2, S_CMPT=3 (shared with the write engine)
  - AXI constants BURST_INCR=2'b01, SIZE_8B=3'b011, RESP_OKAY=2'b00
- No sub-module. The beat counter and error checker stay inline; the block is a single FSM of roughly 150 lines.

Test Plan:
- Reset release, rx_en=1 once rx_rdy=1, addr=0x1000_0007, id=3, arready after 2 cycles, 16 beats with data=i, rresp=0, rlast on beat 15 → araddr=0x1000_0000, arid=3, arlen=15, 16 rx_rvalid pulses with rdata 0..15, rx_rlast on beat 15, rx_err=0, rx_rdy high 2 cycles after the last beat.
- Same burst with rx_rready toggling 1,0 and rvalid randomly gapped → exactly 16 transfers, no duplicates or drops, rready tracks rx_rready only in S_DATA.
- rresp=2'b10 on beat 5 → all 16 beats delivered, rx_err=1 at rx_rdy; next request clears rx_err to 0.
- rlast asserted on beat 9 → burst ends after 10 beats, rx_rlast on beat 9, rx_err=1, FSM returns to idle.
- rid=5 against arid=3 on beat 0 → rx_err=1; rx_en pulsed during S_DATA → ignored, no second arvalid.
- Reset asserted mid-S_DATA (beat 7) → arvalid=0, rready=0, and rx_rdy=0 immediately; rx_rdy=1 one cycle after release; a new burst completes cleanly.

Source files
------------

// File: rtl/tc_ps_acp_pkg.sv
// Shared definitions for the Zynq PS ACP read/write engines.
// State encodings and AXI3 constants used by both directions.
package tc_ps_acp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CMPT = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/tc_ps_acp_rx.sv
// ACP read engine: one user request becomes one INCR burst.
// Beats stream straight through; errors are sticky per burst.
module tc_ps_acp_rx
  import tc_ps_acp_pkg::*;
#(
  parameter int          BURST_LEN = 16,
  parameter logic [3:0]  AR_CACHE  = 4'b0011,
  parameter logic [4:0]  AR_USER   = 5'b00001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en,
  output logic        rx_rdy,
  input  logic [31:0] rx_araddr,
  input  logic [2:0]  rx_arid,
  output logic [63:0] rx_rdata,
  output logic        rx_rvalid,
  output logic        rx_rlast,
  input  logic        rx_rready,
  output logic        rx_err,
  output logic [31:0] S_AXI_ACP_0_araddr,
  output logic [1:0]  S_AXI_ACP_0_arburst,
  output logic [3:0]  S_AXI_ACP_0_arcache,
  output logic [2:0]  S_AXI_ACP_0_arid,
  output logic [3:0]  S_AXI_ACP_0_arlen,
  output logic [1:0]  S_AXI_ACP_0_arlock,
  output logic [2:0]  S_AXI_ACP_0_arprot,
  output logic [3:0]  S_AXI_ACP_0_arqos,
  input  logic        S_AXI_ACP_0_arready,
  output logic [2:0]  S_AXI_ACP_0_arsize,
  output logic [4:0]  S_AXI_ACP_0_aruser,
  output logic        S_AXI_ACP_0_arvalid,
  input  logic [63:0] S_AXI_ACP_0_rdata,
  input  logic [2:0]  S_AXI_ACP_0_rid,
  input  logic        S_AXI_ACP_0_rlast,
  output logic        S_AXI_ACP_0_rready,
  input  logic [1:0]  S_AXI_ACP_0_rresp,
  input  logic        S_AXI_ACP_0_rvalid
);

  localparam logic [4:0] LAST_CNT = 5'(BURST_LEN - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_araddr;
  logic [2:0]  r_arid;
  logic        r_arvalid;
  logic        r_rdy;
  logic        r_err;
  logic [4:0]  r_cnt;

  logic w_beat;
  logic w_final;
  logic w_done;
  logic w_bad;

  assign w_beat  = (r_state == S_DATA) & S_AXI_ACP_0_rvalid
                 & rx_rready;
  assign w_final = (r_cnt == LAST_CNT);
  assign w_done  = w_beat & (S_AXI_ACP_0_rlast | w_final);

  // rlast must coincide exactly with the counted final beat
  assign w_bad = (S_AXI_ACP_0_rresp != RESP_OKAY)
               | (S_AXI_ACP_0_rid != r_arid)
               | (S_AXI_ACP_0_rlast ^ w_final);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_CMPT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CMPT: w_next = S_IDLE;
      S_IDLE: if (rx_en) w_next = S_ADDR;
      S_ADDR: if (S_AXI_ACP_0_arready) w_next = S_DATA;
      S_DATA: if (w_done) w_next = S_CMPT;
      default: w_next = S_CMPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arvalid <= 1'b0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        S_CMPT: r_rdy <= 1'b1;
        S_IDLE: begin
          if (rx_en) begin
            r_araddr  <= {rx_araddr[31:3], 3'b000};
            r_arid    <= rx_arid;
            r_arvalid <= 1'b1;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        S_ADDR: begin
          if (S_AXI_ACP_0_arready) begin
            r_arvalid <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_bad) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    S_AXI_ACP_0_rready = (r_state == S_DATA) & rx_rready;
    rx_rvalid = S_AXI_ACP_0_rvalid & S_AXI_ACP_0_rready;
    rx_rlast  = rx_rvalid & (S_AXI_ACP_0_rlast | w_final);
  end

  assign rx_rdy   = r_rdy;
  assign rx_err   = r_err;
  assign rx_rdata = S_AXI_ACP_0_rdata;

  assign S_AXI_ACP_0_araddr  = r_araddr;
  assign S_AXI_ACP_0_arid    = r_arid;
  assign S_AXI_ACP_0_arvalid = r_arvalid;
  assign S_AXI_ACP_0_arburst = BURST_INCR;
  assign S_AXI_ACP_0_arsize  = SIZE_8B;
  assign S_AXI_ACP_0_arlen   = 4'(BURST_LEN - 1);
  assign S_AXI_ACP_0_arlock  = 2'b00;
  assign S_AXI_ACP_0_arprot  = 3'b000;
  assign S_AXI_ACP_0_arqos   = 4'b0000;
  assign S_AXI_ACP_0_arcache = AR_CACHE;
  assign S_AXI_ACP_0_aruser  = AR_USER;

endmodule
